// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle between the memory-stage access unit and the data memory.
interface mem_access_unit_if;
   logic        DMemReq;
   logic        DMemWe;
   logic [31:0] DMemAddr;
   logic [3:0]  DMemByteEn;
   logic [31:0] DMemWData;
   logic [31:0] DMemRData;
   logic        DMemAck;

   modport master (
      output DMemReq, DMemWe, DMemAddr, DMemByteEn, DMemWData,
      input  DMemRData, DMemAck
   );

   modport slave (
      input  DMemReq, DMemWe, DMemAddr, DMemByteEn, DMemWData,
      output DMemRData, DMemAck
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: req/ack handshake with a variable-latency data memory.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                MemReadIn,
   input  logic                MemWriteIn,
   input  logic [1:0]          bytes2LoadIn,
   input  logic [1:0]          bytes2StoreIn,
   input  logic                LoadUnsignedIn,
   input  logic [31:0]         AddressIn,
   input  logic [31:0]         MemWriteDataIn,
   mem_access_unit_if.master   dMemBus,
   output logic [31:0]         LoadDataOut,
   output logic                LoadValidOut,
   output logic                StallOut,
   output logic                BusErrOut,
   output logic                MisalignErrOut
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state, nextState;
   logic        request, accept, misaligned, timeoutHit;
   logic [1:0]  reqSize;
   logic [1:0]  sizeReg, laneReg;
   logic        writeReg, unsignedReg;
   logic [15:0] timeoutCnt;

   function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
         2'b10:   return 4'b0001 << lane;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b01:   return {2{d[15:0]}};
         2'b10:   return {4{d[7:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] extractLoad(input logic [1:0] size, input logic [1:0] lane,
                                               input logic uns, input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(rdata >> {lane, 3'b000});
      h = lane[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         2'b01:   return uns ? {16'h0000, h} : {{16{h[15]}}, h};
         2'b10:   return uns ? {24'h000000, b} : {{24{b[7]}}, b};
         default: return rdata;
      endcase
   endfunction

   // Simultaneous read+write is treated as a store, so the store size wins.
   assign request    = MemReadIn | MemWriteIn;
   assign reqSize    = MemWriteIn ? bytes2StoreIn : bytes2LoadIn;
   assign accept     = (state == IDLE) && request;
   assign timeoutHit = ({1'b0, timeoutCnt} + 17'd1) >= 17'(TIMEOUT_CYCLES);

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = ((reqSize == 2'b01) && AddressIn[0]) ||
                       ((reqSize == 2'b00 || reqSize == 2'b11) && (AddressIn[1:0] != 2'b00));

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         MisalignErrOut <= 1'b0;
      else if (accept && misaligned)
         MisalignErrOut <= 1'b1;
   end
`else
   assign misaligned     = 1'b0;
   assign MisalignErrOut = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState       = state;
      dMemBus.DMemReq = 1'b0;
      StallOut        = 1'b0;
      LoadValidOut    = 1'b0;
      case (state)
         IDLE: begin
            StallOut = request;
            if (request)
               nextState = misaligned ? DONE : ACCESS;
         end
         ACCESS: begin
            dMemBus.DMemReq = 1'b1;
            StallOut        = 1'b1;
            if (dMemBus.DMemAck || timeoutHit)
               nextState = DONE;
         end
         DONE: begin
            LoadValidOut = !writeReg;
            nextState    = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         sizeReg            <= '0;
         laneReg            <= '0;
         writeReg           <= 1'b0;
         unsignedReg        <= 1'b0;
         timeoutCnt         <= '0;
         dMemBus.DMemWe     <= 1'b0;
         dMemBus.DMemAddr   <= '0;
         dMemBus.DMemByteEn <= '0;
         dMemBus.DMemWData  <= '0;
         LoadDataOut        <= '0;
         BusErrOut          <= 1'b0;
      end else begin
         if (accept) begin
            sizeReg            <= reqSize;
            laneReg            <= AddressIn[1:0];
            writeReg           <= MemWriteIn;
            unsignedReg        <= LoadUnsignedIn;
            timeoutCnt         <= '0;
            dMemBus.DMemWe     <= MemWriteIn;
            dMemBus.DMemAddr   <= {AddressIn[31:2], 2'b00};
            dMemBus.DMemByteEn <= byteEnable(reqSize, AddressIn[1:0]);
            dMemBus.DMemWData  <= storeData(reqSize, MemWriteDataIn);
            if (misaligned && !MemWriteIn)
               LoadDataOut <= '0;
         end
         if (state == ACCESS) begin
            // Ack wins over a timeout landing in the same cycle.
            if (dMemBus.DMemAck) begin
               if (!writeReg)
                  LoadDataOut <= extractLoad(sizeReg, laneReg, unsignedReg, dMemBus.DMemRData);
            end else begin
               timeoutCnt <= timeoutCnt + 16'd1;
               if (timeoutHit) begin
                  BusErrOut <= 1'b1;
                  if (!writeReg)
                     LoadDataOut <= '0;
               end
            end
         end
      end
   end

endmodule
